// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: strips E0/F0 prefixes, suppresses typematic
// repeats and queues key events in a small first-word-fall-through FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYC     = 200000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       dspclk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] last_code,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } event_t;

  state_t          state, state_next;
  logic [TW-1:0]   tmo_cnt;
  logic            timeout;
  logic            emit;
  logic            emit_ext;
  logic            emit_brk;
  logic            byte_ok;

  logic [7:0]      held_code;
  logic            held_ext;
  logic            held_valid;
  logic            held_hit;
  logic            drop_repeat;
  logic            push_req;

  event_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            pop;
  logic            wr_en;
  event_t          head;

  assign byte_ok = rx_valid && !rx_err;
  assign timeout = (state != S_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    if (rx_valid && rx_err) begin
      state_next = S_IDLE;
    end else if (byte_ok) begin
      unique case (state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_next = S_E0;
          else if (rx_data == 8'hF0) state_next = S_F0;
          else if (!(rx_data inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1}))
            emit = 1'b1;
        end
        S_E0: begin
          if (rx_data == 8'hF0)      state_next = S_E0F0;
          else if (rx_data != 8'hE0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = S_IDLE;
          end
        end
        S_F0, S_E0F0: begin
          state_next = S_IDLE;
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state == S_E0F0);
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (timeout) begin
      state_next = S_IDLE;
    end
  end

  assign held_hit    = held_valid && (held_code == rx_data) && (held_ext == emit_ext);
  assign drop_repeat = emit && !emit_brk && held_hit && (SUPPRESS_REPEAT != 0);
  assign push_req    = emit && !drop_repeat;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign wr_en    = push_req && (!full || pop);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_next;
      if (rx_valid || timeout || state == S_IDLE) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge dspclk) begin
    if (reset) begin
      held_code  <= '0;
      held_ext   <= 1'b0;
      held_valid <= 1'b0;
    end else if (emit && !emit_brk && !drop_repeat) begin
      held_code  <= rx_data;
      held_ext   <= emit_ext;
      held_valid <= 1'b1;
    end else if (emit && emit_brk && held_hit) begin
      held_valid <= 1'b0;
    end
  end

  always_ff @(posedge dspclk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_code <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !emit_brk)          last_code <= rx_data;
      if (push_req && full && !pop)    overflow  <= 1'b1;
    end
  end

  // NOTE: the storage array carries no reset; occupancy gates what is visible,
  // so stale entries never reach the outputs.
  always_ff @(posedge dspclk) begin
    if (wr_en) mem[wr_ptr] <= '{code: rx_data, ext: emit_ext, brk: emit_brk};
  end

  assign head     = ev_valid ? mem[rd_ptr] : '0;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Sits directly downstream of hid_controller and consumes its received PS/2 bytes. It strips the Set-2 prefixes (0xE0 extended, 0xF0 break), suppresses typematic repeats, and queues decoded key events in a small first-word-fall-through FIFO with a valid/ready handshake. It also holds the most recent make code for the LED display.

Parameters:
FIFO_DEPTH, 4, event FIFO depth; power of two, 2..16.
TIMEOUT_CYC, 200000, dspclk cycles a pending prefix may wait for its next byte (2 ms at 100 MHz).
SUPPRESS_REPEAT, 1, 1 = drop a repeated make of the currently held key.

Ports:
dspclk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  byte from hid_controller.
rx_valid  in  1  one-cycle strobe; rx_data and rx_err are valid this cycle.
rx_err  in  1  parity error for the byte on rx_data; sampled only with rx_valid.
ev_code  out  8  scancode of the event at the FIFO head.
ev_ext  out  1  event carried the 0xE0 prefix.
ev_break  out  1  1 = key release, 0 = key press.
ev_valid  out  1  FIFO non-empty.
ev_ready  in  1  consumer accepts; pop occurs when ev_valid && ev_ready.
last_code  out  8  code of the most recent make event pushed to the FIFO.
overflow  out  1  sticky flag: an event was lost because the FIFO was full.

Behaviour:
- Interface: one clock, dspclk; reset is synchronous and active-high.
- Reset: FSM to IDLE, FIFO empty, held key cleared, timeout counter cleared. All outputs read 0 (ev_valid=0, ev_code/ev_ext/ev_break=0, last_code=0x00, overflow=0). A reset mid-prefix discards the prefix.
- FSM states: IDLE, E0, F0, E0F0. Transitions occur only on rx_valid with rx_err=0.
  - IDLE: 0xE0 goes to E0. 0xF0 goes to F0. 0xAA, 0xFA, 0xEE, 0xFE, 0x00, 0xFF and 0xE1 are dropped and the FSM stays in IDLE. Any other byte emits make{code, ext=0}.
  - E0: 0xF0 goes to E0F0. 0xE0 is ignored and the FSM stays in E0. Any other byte emits make{code, ext=1} and returns to IDLE.
  - F0: any byte except 0xE0/0xF0 emits break{code, ext=0} and returns to IDLE. 0xE0 or 0xF0 here returns to IDLE without an event.
  - E0F0: any byte except 0xE0/0xF0 emits break{code, ext=1} and returns to IDLE. 0xE0 or 0xF0 here returns to IDLE without an event.
- Known limitation: the Pause sequence is unsupported. 0xE1 is dropped; the bytes that follow it decode as ordinary codes.
- Parity error: rx_valid with rx_err=1 drops the byte and forces IDLE from any state. No event is produced.
- Timeout: the counter clears on every accepted byte and increments each cycle while the FSM is not in IDLE. When it reaches TIMEOUT_CYC-1, the FSM returns to IDLE and the prefix is discarded.
- Repeat suppression: a held register stores {code, ext} and a valid bit.
  - A make whose {code, ext} equals the held entry (valid) is dropped when SUPPRESS_REPEAT=1.
  - Any other make loads the held register.
  - A break matching the held entry clears the valid bit.
  - A break never suppresses itself.
- last_code: updates on every make pushed into the FIFO. It does not update on a dropped make.
- Latency: rx_valid at edge N gives ev_valid=1 with the event at the head after edge N+1 when the FIFO was empty.
- FIFO write/read rules:
  - Write when an event is emitted and (not full, or a pop occurs this same cycle).
  - On full with no pop, the event is dropped and overflow is set to 1; only reset clears it.
  - Push and pop together on a non-empty FIFO leave occupancy unchanged.
  - ev_code/ev_ext/ev_break hold steady while ev_valid=1 and ev_ready=0.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH; occupancy uses log2(FIFO_DEPTH)+1 bits.

Test Plan:
1. After reset, rx 0x1C -> one cycle later ev_valid=1, ev_code=0x1C, ev_ext=0, ev_break=0, last_code=0x1C. Pulse ev_ready -> ev_valid=0.
2. rx 0xF0, 0x1C -> single event 0x1C with break=1, held cleared. Then rx 0xE0, 0x75 -> make with ext=1. Then rx 0xE0, 0xF0, 0x75 -> break with ext=1. last_code=0x75.
3. Repeat: rx 0x1C three times with ev_ready=1 -> exactly one event. Then F0 1C -> break event. Then 0x1C -> new make event.
4. Overflow: ev_ready=0, rx makes 0x15, 0x1D, 0x24, 0x2D, 0x2C -> first 4 queued in order, overflow=1. Drain with ev_ready=1 -> 0x15, 0x1D, 0x24, 0x2D, then ev_valid=0.
5. Timeout: rx 0xF0, idle TIMEOUT_CYC cycles, rx 0x1C -> make event (break=0). The same stimulus with a gap below TIMEOUT_CYC gives a break event.
6. Errors: rx 0xE0, then 0xF0 with rx_err=1, then 0x74 -> make 0x74 with ext=0. Reset asserted between 0xF0 and 0x1C -> after reset, 0x1C gives a make event and overflow=0.
